calc_display_core: RTL
======================

Name: calc_display_core

Overview:
- Parametrised successor to the switch-driven ALU/seven-segment top.
- Holds a RES_W-bit accumulator. Each debounced-clean `exec` rising edge applies `acc <= acc OP num1`.
- Drives a time-multiplexed hex display of the accumulator across DIGITS digits, with sticky overflow and zero flags.
- Sits directly under the board top; switches and buttons in, `seg`/`ans` out.

Parameters:
- IN_W, 8: operand width from switches; zero-extended to RES_W.
- RES_W, 32: accumulator width; must equal 4*DIGITS.
- DIGITS, 8: number of display digits / anodes.
- SCAN_DIV, 100000: clk cycles each digit stays active (must be ≥2).
- BLANK_LZ, 1: 1 = blank leading-zero digits (digit 0 never blanked); 0 = show all digits.

Ports:
- clk, input, 1: single system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- num1, input, IN_W: operand B (switches).
- op, input, 3: operation select.
- exec, input, 1: level input; its rising edge triggers one operation.
- clr, input, 1: synchronous accumulator clear, level.
- seg, output, 7: active-low segments, seg[0]=a … seg[6]=g.
- ans, output, DIGITS: active-low anodes, ans[0] = least-significant nibble.
- ovf, output, 1: sticky signed overflow.
- zero, output, 1: high when acc == 0.

Behaviour:
- Reset, synchronous, in the same edge:
  - acc=0, exec_d=0, ovf=0, div=0, idx=0.
  - Outputs: ans = all ones except ans[0]=0; seg=7'h40 (glyph 0); zero=1.
  - Reset overrides clr and exec in the same cycle.
- Edge detect:
  - exec_d <= exec every cycle; pulse = exec & ~exec_d.
  - Holding exec high executes exactly once.
  - A pulse that coincides with reset is lost.
- Operand: b = {zero pad, num1}; shamt = b[log2(RES_W)-1:0].
- Ops, applied at the same edge the pulse is sampled; result visible next cycle (latency 1):
  - 000: add, acc+b.
  - 001: sub, acc-b.
  - 010: and.
  - 011: or.
  - 100: xor.
  - 101: sll by shamt.
  - 110: srl (logical) by shamt.
  - 111: load, acc<=b.
- Arithmetic:
  - Results wrap modulo 2^RES_W.
  - ovf <= ovf | signed overflow, computed only for add/sub:
    - add: operand sign bits equal and result sign bit differs.
    - sub: operand sign bits differ and result sign bit differs from acc.
  - All other ops leave ovf unchanged.
- clr: acc<=0 and ovf<=0. clr has priority over a simultaneous exec pulse; that pulse is discarded, but exec_d still updates.
- zero: combinational (acc == 0).
- Scanner:
  - div counts 0..SCAN_DIV-1.
  - At terminal count div wraps to 0 and idx advances, wrapping DIGITS-1 → 0.
  - ans[idx]=0, all others 1.
  - seg is registered together with ans, so they never mismatch by a cycle.
- Glyphs: standard hex, active-low, in {g..a} order:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Blanking: when BLANK_LZ=1, idx≠0 and nibbles idx..DIGITS-1 are all zero, the digit is blanked: its anode stays low but seg=7'h7F.
- Live display: an acc change mid-scan is shown from the next digit refresh; the scanner is not restarted.

Test Plan:
1. Parameters DIGITS=8, SCAN_DIV=4, BLANK_LZ=1. Assert reset for 2 cycles -> acc=0, zero=1, ovf=0, ans=8'hFE, seg=7'h40. Then ans walks FE, FD, FB, …, 7F, each held exactly 4 cycles; digits 1..7 show seg=7'h7F.
2. op=111, num1=0x3A, exec pulse; then op=000, num1=0x05, with exec held high 10 cycles -> acc=0x3F one cycle after each edge, only one add. Digit0 seg=7'h0E (F), digit1 seg=7'h30 (3), zero=0.
3. Load 0x01, then sll with num1=0x1F -> acc=0x80000000, ovf=0. Then sub with num1=0x01 -> acc=0x7FFFFFFF, ovf=1. Then add with num1=0x01 -> acc=0x80000000, ovf stays 1. Then clr -> acc=0, ovf=0, zero=1.
4. acc=0, sub with num1=0x01 -> acc=0xFFFFFFFF, ovf=0; all 8 digits show 7'h0E, no blanking.
5. clr and an exec edge in the same cycle, with op=111, num1=0x55 -> acc=0. exec stays high afterwards -> no later load occurs.
6. Reset asserted mid-scan (idx=5, div=2) and during an exec edge -> next cycle idx=0, div=0, acc=0, ans=8'hFE. The exec level still high after reset causes a load on the following cycle (exec_d was cleared).

Source files
------------

// File: rtl/calc_display_core.sv
// Switch-driven accumulator (acc <= acc OP num1 on each exec rising edge) with a multiplexed hex display.
// Latency 1 cycle from exec edge to acc; display refreshes per digit slot; no backpressure (free-running scanner).
module calc_display_core #(
    parameter int IN_W     = 8,
    parameter int RES_W    = 32,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000,
    parameter int BLANK_LZ = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN_W-1:0]   num1,
    input  logic [2:0]        op,
    input  logic              exec,
    input  logic              clr,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] ans,
    output logic              ovf,
    output logic              zero
);
    localparam int SH_W  = $clog2(RES_W);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_LD  = 3'b111
    } op_t;

    logic [RES_W-1:0]  acc_q, acc_d;
    logic              exec_prev_q, exec_prev_d;
    logic              ovf_q, ovf_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] ans_q, ans_d;

    logic [RES_W-1:0]  b;
    logic [SH_W-1:0]   shamt;
    logic [RES_W-1:0]  sum, diff, alu_res;
    logic              alu_ovf;
    logic              pulse;
    logic              div_wrap;
    logic [RES_W-1:0]  upper;
    logic              blank;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase
    endfunction

    always_comb begin
        b              = '0;
        b[IN_W-1:0]    = num1;
        shamt          = b[SH_W-1:0];
        pulse          = exec & ~exec_prev_q;
        exec_prev_d    = exec;
        sum            = acc_q + b;
        diff           = acc_q - b;
        alu_res        = acc_q;
        alu_ovf        = 1'b0;
        case (op_t'(op))
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (acc_q[RES_W-1] == b[RES_W-1]) && (sum[RES_W-1] != acc_q[RES_W-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (acc_q[RES_W-1] != b[RES_W-1]) && (diff[RES_W-1] != acc_q[RES_W-1]);
            end
            OP_AND:  alu_res = acc_q & b;
            OP_OR:   alu_res = acc_q | b;
            OP_XOR:  alu_res = acc_q ^ b;
            OP_SLL:  alu_res = acc_q << shamt;
            OP_SRL:  alu_res = acc_q >> shamt;
            default: alu_res = b;
        endcase

        // clr wins over a coincident exec pulse, which is simply dropped
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (pulse) begin
            acc_d = alu_res;
            ovf_d = ovf_q | alu_ovf;
        end
    end

    always_comb begin
        div_wrap = (div_q == DIV_W'(SCAN_DIV - 1));
        div_d    = div_wrap ? '0 : div_q + 1'b1;
        idx_d    = idx_q;
        if (div_wrap) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        // Glyph is captured only at a digit change so seg and ans always move together
        upper = acc_q >> {idx_d, 2'b00};
        blank = (BLANK_LZ != 0) && (idx_d != '0) && (upper == '0);
        seg_d = seg_q;
        ans_d = ans_q;
        if (div_wrap) begin
            ans_d = ~(DIGITS'(1) << idx_d);
            seg_d = blank ? 7'h7F : hex_glyph(upper[3:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            exec_prev_q <= 1'b0;
            ovf_q       <= 1'b0;
            div_q       <= '0;
            idx_q       <= '0;
            seg_q       <= 7'h40;
            ans_q       <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            acc_q       <= acc_d;
            exec_prev_q <= exec_prev_d;
            ovf_q       <= ovf_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            ans_q       <= ans_d;
        end
    end

    assign seg  = seg_q;
    assign ans  = ans_q;
    assign ovf  = ovf_q;
    assign zero = (acc_q == '0);

endmodule
